pb_debounce: RTL and testbench

Multi-bit pushbutton conditioner sitting directly upstream of the wheel-position counter block. It takes raw, asynchronous, bouncing Nexys 3 pushbutton/switch levels, synchronizes them to `clk`, and holds each bit's debounced level steady until the new level has been stable for a full debounce interval. Its outputs drive `left_fwd`, `left_rev`, `right_fwd` and `right_rev` (plus spares), plus optional single-cycle edge strobes.

---
 rtl/pb_debounce_if.sv | 24 ++
 rtl/pb_debounce.sv | 122 ++++++++++++
 tb/tb_pb_debounce.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pb_debounce_if.sv
// pb_debounce_if: raw button levels in, debounced levels and edge strobes out.
// master = the block feeding raw levels / consuming results; slave = the debouncer.
interface pb_debounce_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] pb_in;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] db_rise;
    logic [WIDTH-1:0] db_fall;

    modport master (
        output pb_in,
        input  db_out,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  pb_in,
        output db_out,
        output db_rise,
        output db_fall
    );
endinterface

// File: rtl/pb_debounce.sv
// pb_debounce: per-bit two-flop synchronizer followed by an independent
// STABLE/CHECK debounce FSM and 20-bit stability counter for each bit.
// Optional feature macro: PB_DEBOUNCE_EDGE_EN -- when defined, registered
// one-cycle rise/fall strobes are built; otherwise db_rise/db_fall are tied 0.
module pb_debounce #(
    parameter int WIDTH    = 5,
    parameter int SIMULATE = 0
) (
    input logic               clk,
    input logic               reset,
    pb_debounce_if.slave      bus
);
    localparam int          DB_COUNT = (SIMULATE != 0) ? 4 : 1_000_000;
    localparam logic [19:0] CNT_LAST = 20'(DB_COUNT - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Two-flop synchronizer; only r_s2 is seen by the debounce logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.pb_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        state_t      r_state;
        state_t      w_state_nxt;
        logic [19:0] r_cnt;
        logic [19:0] w_cnt_nxt;
        logic        r_db;
        logic        w_diff;
        logic        w_take;

        assign w_diff = r_s2[g] ^ r_db;

        // Next-state/counter logic: a difference must survive DB_COUNT+1
        // consecutive samples; any sample matching db_out restarts the wait.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_take      = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_diff) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CHECK: begin
                    if (!w_diff) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_take      = 1'b1;
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 20'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // State, counter and debounced level registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_db    <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_take) r_db <= r_s2[g];
            end
        end

        assign w_db[g] = r_db;

`ifdef PB_DEBOUNCE_EDGE_EN
        logic r_rise;
        logic r_fall;

        // Strobes are registered alongside r_db so they coincide with the level change.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= w_take &  r_s2[g];
                r_fall <= w_take & ~r_s2[g];
            end
        end

        assign w_rise[g] = r_rise;
        assign w_fall[g] = r_fall;
`else
        assign w_rise[g] = 1'b0;
        assign w_fall[g] = 1'b0;
`endif
    end

    assign bus.db_out  = w_db;
    assign bus.db_rise = w_rise;
    assign bus.db_fall = w_fall;
endmodule

// File: tb/tb_pb_debounce.sv
// tb_pb_debounce: directed stimulus pushes expected output events (cycle,
// level, strobes) into a queue; a monitor pops one entry for every cycle in
// which db_out changes or a strobe is high and compares it.
module tb_pb_debounce;
    localparam int W = 5;

    typedef struct {
        int         cyc;
        logic [4:0] db;
        logic [4:0] rise;
        logic [4:0] fall;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   ncmp;
    int   nfail;
    exp_t sb[$];

    pb_debounce_if #(.WIDTH(W)) u_if ();

    pb_debounce #(.WIDTH(W), .SIMULATE(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        ncmp++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Expected strobes only exist when the edge feature is compiled in.
    task automatic push(input int at, input logic [4:0] db,
                        input logic [4:0] rise, input logic [4:0] fall);
        exp_t e;
        e.cyc = at;
        e.db  = db;
`ifdef PB_DEBOUNCE_EDGE_EN
        e.rise = rise;
        e.fall = fall;
`else
        e.rise = 5'b0;
        e.fall = 5'b0;
`endif
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: any level change or strobe is an output event to be checked.
    initial begin
        logic [4:0] prev;
        exp_t       e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = '0;
            end else begin
                if ((u_if.db_out != prev) || (|u_if.db_rise) || (|u_if.db_fall)) begin
                    if (sb.size() == 0) begin
                        ncmp++;
                        nfail++;
                        $display("FAIL unexpected_event at cycle %0d: db_out=%b rise=%b fall=%b, expected no event",
                                 cyc, u_if.db_out, u_if.db_rise, u_if.db_fall);
                    end else begin
                        e = sb.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("db_out", int'(u_if.db_out), int'(e.db));
                        chk("db_rise", int'(u_if.db_rise), int'(e.rise));
                        chk("db_fall", int'(u_if.db_fall), int'(e.fall));
                    end
                end
                prev = u_if.db_out;
            end
        end
    end

    initial begin
        ncmp  = 0;
        nfail = 0;
        reset = 1'b1;
        u_if.pb_in = 5'b11111;

        // Reset with all buttons pressed: outputs held at 0.
        tick(3);
        chk("reset_db_out", int'(u_if.db_out), 0);
        chk("reset_db_rise", int'(u_if.db_rise), 0);
        chk("reset_db_fall", int'(u_if.db_fall), 0);
        reset = 1'b0;
        push(cyc + 7, 5'b11111, 5'b11111, 5'b00000);
        tick(12);

        // Release everything.
        u_if.pb_in = 5'b00000;
        push(cyc + 7, 5'b00000, 5'b00000, 5'b11111);
        tick(12);

        // Clean step on bit 0, both directions.
        u_if.pb_in = 5'b00001;
        push(cyc + 7, 5'b00001, 5'b00001, 5'b00000);
        tick(12);
        u_if.pb_in = 5'b00000;
        push(cyc + 7, 5'b00000, 5'b00000, 5'b00001);
        tick(12);

        // Bounce on bit 1: 1,0,1,0 two cycles each, then hold 1.
        u_if.pb_in = 5'b00010; tick(2);
        u_if.pb_in = 5'b00000; tick(2);
        u_if.pb_in = 5'b00010; tick(2);
        u_if.pb_in = 5'b00000; tick(2);
        u_if.pb_in = 5'b00010;
        push(cyc + 7, 5'b00010, 5'b00010, 5'b00000);
        tick(12);
        u_if.pb_in = 5'b00000;
        push(cyc + 7, 5'b00000, 5'b00000, 5'b00010);
        tick(12);

        // Glitches on bit 2 of 3 and 4 cycles are rejected.
        u_if.pb_in = 5'b00100; tick(3);
        u_if.pb_in = 5'b00000; tick(12);
        u_if.pb_in = 5'b00100; tick(4);
        u_if.pb_in = 5'b00000; tick(12);

        // A 5-cycle pulse is the shortest one accepted.
        u_if.pb_in = 5'b00100;
        push(cyc + 7, 5'b00100, 5'b00100, 5'b00000);
        tick(5);
        u_if.pb_in = 5'b00000;
        push(cyc + 7, 5'b00000, 5'b00000, 5'b00100);
        tick(12);

        // Two bits rising together, then falling together.
        u_if.pb_in = 5'b10100;
        push(cyc + 7, 5'b10100, 5'b10100, 5'b00000);
        tick(12);
        u_if.pb_in = 5'b00000;
        push(cyc + 7, 5'b00000, 5'b00000, 5'b10100);
        tick(12);

        // Same step, aborted by reset after edge 3; full interval after release.
        u_if.pb_in = 5'b10100;
        tick(3);
        reset = 1'b1;
        #1;
        chk("midreset_db_out", int'(u_if.db_out), 0);
        chk("midreset_db_rise", int'(u_if.db_rise), 0);
        tick(2);
        reset = 1'b0;
        push(cyc + 7, 5'b10100, 5'b10100, 5'b00000);
        tick(12);

        chk("final_db_out", int'(u_if.db_out), 5'b10100);
        chk("events_outstanding", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
